// File: rtl/frac_lutk_cfg_tile_if.sv
// frac_lutk_cfg_tile_if: configuration-chain and LUT signal bundle for frac_lutk_cfg_tile (cfg_err only with FRAC_LUT_CFG_PARITY_EN)
interface frac_lutk_cfg_tile_if #(parameter int K = 4);
    localparam int NSRAM = 1 << K;
`ifdef FRAC_LUT_CFG_PARITY_EN
    localparam int N = NSRAM + 2;
`else
    localparam int N = NSRAM + 1;
`endif
    localparam int CW = $clog2(N + 1);
    logic          ccff_en;
    logic          ccff_head;
    logic [0:K-1]  frac_lut_in;
    logic          ccff_tail;
    logic [0:1]    frac_lut_lutk1_out;
    logic          frac_lut_lutk_out;
    logic [CW-1:0] cfg_count;
    logic          cfg_done;
`ifdef FRAC_LUT_CFG_PARITY_EN
    logic          cfg_err;
    modport master (output ccff_en, ccff_head, frac_lut_in,
                    input ccff_tail, frac_lut_lutk1_out, frac_lut_lutk_out, cfg_count, cfg_done, cfg_err);
    modport slave  (input ccff_en, ccff_head, frac_lut_in,
                    output ccff_tail, frac_lut_lutk1_out, frac_lut_lutk_out, cfg_count, cfg_done, cfg_err);
`else
    modport master (output ccff_en, ccff_head, frac_lut_in,
                    input ccff_tail, frac_lut_lutk1_out, frac_lut_lutk_out, cfg_count, cfg_done);
    modport slave  (input ccff_en, ccff_head, frac_lut_in,
                    output ccff_tail, frac_lut_lutk1_out, frac_lut_lutk_out, cfg_count, cfg_done);
`endif
endinterface

// File: rtl/frac_lutk_cfg_tile.sv
// frac_lutk_cfg_tile: K-input fracturable LUT with counted config shift chain; FRAC_LUT_CFG_PARITY_EN adds an even-parity bit and cfg_err
module frac_lutk_cfg_tile #(
    parameter int K = 4
) (
    input logic                  prog_clk,
    input logic                  pReset,
    frac_lutk_cfg_tile_if.slave  bus
);
    localparam int NSRAM = 1 << K;
`ifdef FRAC_LUT_CFG_PARITY_EN
    localparam int N = NSRAM + 2;
`else
    localparam int N = NSRAM + 1;
`endif
    localparam int CW = $clog2(N + 1);

    logic [0:N-1]     r_mem;
    logic [CW-1:0]    r_cnt;
    logic             r_tail;
    logic [0:NSRAM-1] w_sram;
    logic [K-1:0]     w_idx;
    logic [K-2:0]     w_idx_h;
    logic             w_mode;
    logic             w_done;
    logic             w_err;
    logic             w_gate;

    // Chain shifts toward mem[N-1]; the count saturates at N so extra shifts only pass data through; tail is an extra flop behind mem[N-1]
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_mem  <= '0;
            r_cnt  <= '0;
            r_tail <= 1'b0;
        end else begin
            r_tail <= r_mem[N-1];
            if (bus.ccff_en) begin
                r_mem <= {bus.ccff_head, r_mem[0:N-2]};
                if (r_cnt != CW'(N))
                    r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Input bus is LSB-at-[0]; reorder into a numeric index
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < K; i++)
            w_idx[i] = bus.frac_lut_in[i];
    end

    assign w_sram  = r_mem[0:NSRAM-1];
    assign w_mode  = r_mem[NSRAM];
    assign w_idx_h = w_idx[K-2:0];
    assign w_done  = r_cnt == CW'(N);
`ifdef FRAC_LUT_CFG_PARITY_EN
    assign w_err       = w_done & ^r_mem;
    assign bus.cfg_err = w_err;
`else
    assign w_err = 1'b0;
`endif
    assign w_gate = w_done & ~w_err;

    // LUT read: mode 0 uses the whole table, mode 1 splits it into two halves sharing the low K-1 inputs
    always_comb begin
        bus.frac_lut_lutk_out     = w_gate & ~w_mode & w_sram[w_idx];
        bus.frac_lut_lutk1_out[0] = w_gate & w_mode & w_sram[{1'b0, w_idx_h}];
        bus.frac_lut_lutk1_out[1] = w_gate & w_mode & w_sram[{1'b1, w_idx_h}];
    end

    assign bus.ccff_tail = r_tail;
    assign bus.cfg_count = r_cnt;
    assign bus.cfg_done  = w_done;
endmodule

// File: tb/tb_frac_lutk_cfg_tile.sv
// tb_frac_lutk_cfg_tile: directed bench for frac_lutk_cfg_tile at K=4 (parity checks when FRAC_LUT_CFG_PARITY_EN is defined)
module tb_frac_lutk_cfg_tile;
    localparam int K = 4;
`ifdef FRAC_LUT_CFG_PARITY_EN
    localparam int N = 18;
`else
    localparam int N = 17;
`endif

    logic clk;
    logic rst;
    int   tests;
    int   failed;
    logic seq [0:N+19];

    frac_lutk_cfg_tile_if #(.K(K)) bus ();

    frac_lutk_cfg_tile #(.K(K)) dut (
        .prog_clk (clk),
        .pReset   (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int v);
        for (int i = 0; i < K; i++)
            bus.frac_lut_in[i] = v[i];
    endtask

    task automatic shift(input logic b);
        bus.ccff_head = b;
        bus.ccff_en   = 1'b1;
        @(posedge clk);
        #1;
        bus.ccff_en   = 1'b0;
    endtask

    task automatic reset2();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic load(input logic [15:0] sram, input logic mode, input logic par);
        logic [17:0] v;
        v = {par, mode, sram};
        for (int i = N - 1; i >= 0; i--)
            shift(v[i]);
    endtask

    task automatic chk_out(input string tag, input int v, input logic e_k, input logic e_h0, input logic e_h1);
        set_in(v);
        #1;
        chk({tag, "_lutk"}, 32'(bus.frac_lut_lutk_out), 32'(e_k));
        chk({tag, "_h0"}, 32'(bus.frac_lut_lutk1_out[0]), 32'(e_h0));
        chk({tag, "_h1"}, 32'(bus.frac_lut_lutk1_out[1]), 32'(e_h1));
    endtask

    initial begin
        tests = 0;
        failed = 0;
        rst = 1'b0;
        bus.ccff_en = 1'b0;
        bus.ccff_head = 1'b0;
        set_in(0);

        reset2();
        chk("rst_count", 32'(bus.cfg_count), 0);
        chk("rst_done", 32'(bus.cfg_done), 0);
        chk("rst_tail", 32'(bus.ccff_tail), 0);
        for (int v = 0; v < 16; v++)
            chk_out("rst_out", v, 1'b0, 1'b0, 1'b0);

        load(16'h8000, 1'b0, 1'b1);
        chk("and4_count", 32'(bus.cfg_count), N);
        chk("and4_done", 32'(bus.cfg_done), 1);
        chk_out("and4_1111", 15, 1'b1, 1'b0, 1'b0);
        chk_out("and4_0111", 7, 1'b0, 1'b0, 1'b0);
        chk_out("and4_1110", 14, 1'b0, 1'b0, 1'b0);

        reset2();
        for (int i = 0; i < N - 1; i++) begin
            if (i == N - 1) break;
        end
        load(16'h8001, 1'b1, 1'b1);
        chk("frac_done", 32'(bus.cfg_done), 1);
        chk_out("frac_0000", 0, 1'b0, 1'b1, 1'b0);
        chk_out("frac_0111", 7, 1'b0, 1'b0, 1'b1);
        chk_out("frac_1000", 8, 1'b0, 1'b1, 1'b0);
        chk_out("frac_1111", 15, 1'b0, 1'b0, 1'b1);

        reset2();
        for (int i = 0; i < 10; i++)
            shift(1'b1);
        chk("part_count", 32'(bus.cfg_count), 10);
        chk("part_done", 32'(bus.cfg_done), 0);
        chk_out("part_1111", 15, 1'b0, 1'b0, 1'b0);
        chk_out("part_0000", 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        bus.ccff_en = 1'b1;
        bus.ccff_head = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.ccff_en = 1'b0;
        chk("midrst_count", 32'(bus.cfg_count), 0);
        chk("midrst_done", 32'(bus.cfg_done), 0);
        load(16'h8000, 1'b0, 1'b1);
        chk("reload_count", 32'(bus.cfg_count), N);
        chk_out("reload_1111", 15, 1'b1, 1'b0, 1'b0);

        reset2();
        begin
            logic [17:0] v;
            v = {1'b0, 1'b1, 16'h6B3D};
            for (int k = 0; k < N; k++)
                seq[k] = v[N-1-k];
            for (int m = 0; m < 20; m++)
                seq[N+m] = (m % 3 == 0);
            for (int k = 0; k < N; k++)
                shift(seq[k]);
            chk("pass_loaded", 32'(bus.cfg_count), N);
            for (int j = 1; j <= 20; j++) begin
                shift(seq[N+j-1]);
                chk($sformatf("pass_tail%0d", j), 32'(bus.ccff_tail), 32'(seq[j-1]));
            end
            chk("sat_count", 32'(bus.cfg_count), N);
            chk("sat_done", 32'(bus.cfg_done), 1);
        end

`ifdef FRAC_LUT_CFG_PARITY_EN
        reset2();
        load(16'h8000, 1'b0, 1'b0);
        chk("par_bad_done", 32'(bus.cfg_done), 1);
        chk("par_bad_err", 32'(bus.cfg_err), 1);
        chk_out("par_bad_1111", 15, 1'b0, 1'b0, 1'b0);
        reset2();
        for (int i = 0; i < 5; i++)
            shift(1'b1);
        chk("par_part_err", 32'(bus.cfg_err), 0);
        reset2();
        load(16'h8000, 1'b0, 1'b1);
        chk("par_ok_err", 32'(bus.cfg_err), 0);
        chk_out("par_ok_1111", 15, 1'b1, 1'b0, 1'b0);
        chk_out("par_ok_0111", 7, 1'b0, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
